seg_scan_ctrl: RTL and testbench

Digit-scan controller for the 8-digit seven-segment display. It sits directly upstream of the 8:1 nibble multiplexer and drives that mux's 3-bit select with the current digit index. It also drives the matching active-low anode enables, with brightness PWM, per-digit blanking and an anti-ghosting guard interval. The segment decoder downstream of the mux needs no change.

---
 rtl/seg_scan_if.sv | 20 ++
 rtl/seg_scan_ctrl.sv | 74 +++++++
 tb/tb_seg_scan_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Scan-side signal bundle between the display scan controller and its user:
// control inputs (enable, brightness, blanking) and the mux select / anode outputs.
interface seg_scan_if;
    logic       en;
    logic [2:0] brightness;
    logic [7:0] blank_mask;
    logic [2:0] seg_sel;
    logic [7:0] an;
    logic       digit_tick;

    modport master (
        output en, brightness, blank_mask,
        input  seg_sel, an, digit_tick
    );

    modport slave (
        input  en, brightness, blank_mask,
        output seg_sel, an, digit_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller: per-slot digit select, brightness PWM,
// per-digit blanking and an all-off guard at the start of each slot.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic      clk,
    input  logic      reset,
    seg_scan_if.slave scan
);
    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam int            TW      = CW + 1;
    localparam logic [CW-1:0] LAST    = CW'(REFRESH_DIV - 1);
    localparam logic [TW-1:0] SLOT8   = TW'(REFRESH_DIV >> 3);
    localparam logic [TW-1:0] GUARD_W = TW'(GUARD);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    seg_sel_q, seg_sel_d;
    logic [2:0]    bright_q, bright_d;
    logic [7:0]    an_q, an_d;
    logic          digit_tick_q, digit_tick_d;
    logic [TW-1:0] thr;
    logic          lit;

    always_comb begin
        cnt_d        = cnt_q;
        seg_sel_d    = seg_sel_q;
        bright_d     = bright_q;
        digit_tick_d = 1'b0;
        if (scan.en) begin
            if (cnt_q == LAST) begin
                cnt_d     = '0;
                seg_sel_d = seg_sel_q + 3'd1;
                bright_d  = scan.brightness;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            digit_tick_d = (cnt_d == LAST);
        end

        // (bright+1) * slot/8 as a shift-and-add over the three brightness bits
        thr = SLOT8
            + (bright_d[0] ? SLOT8        : '0)
            + (bright_d[1] ? (SLOT8 << 1) : '0)
            + (bright_d[2] ? (SLOT8 << 2) : '0);

        // Anodes are built from next-state select so they never lead or lag seg_sel
        lit  = scan.en
            && ({1'b0, cnt_d} >= GUARD_W)
            && ({1'b0, cnt_d} < thr)
            && !scan.blank_mask[seg_sel_d];
        an_d = lit ? ~(8'b1 << seg_sel_d) : 8'hFF;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            seg_sel_q    <= 3'd0;
            bright_q     <= 3'b111;
            an_q         <= 8'hFF;
            digit_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            seg_sel_q    <= seg_sel_d;
            bright_q     <= bright_d;
            an_q         <= an_d;
            digit_tick_q <= digit_tick_d;
        end
    end

    assign scan.seg_sel    = seg_sel_q;
    assign scan.an         = an_q;
    assign scan.digit_tick = digit_tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a 16-cycle slot and 1-cycle guard.
module tb_seg_scan_ctrl;
    localparam int RD = 16;
    localparam int GD = 1;

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] an;
        logic       tick;
    } exp_t;

    logic clk;
    logic reset;
    seg_scan_if sif();

    seg_scan_ctrl #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk   (clk),
        .reset (reset),
        .scan  (sif)
    );

    int   checks   = 0;
    int   failures = 0;
    int   m_cnt, m_sel, m_bright;
    exp_t sb[$];
    event obs_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the reference slot model by one clock, queue its prediction, then clock the DUT.
    task automatic advance();
        exp_t e;
        int   thr;
        logic lit;
        if (sif.en) begin
            if (m_cnt == RD - 1) begin
                m_cnt    = 0;
                m_sel    = (m_sel + 1) % 8;
                m_bright = int'(sif.brightness);
            end else begin
                m_cnt++;
            end
        end
        thr    = (m_bright + 1) * (RD / 8);
        lit    = sif.en && (m_cnt >= GD) && (m_cnt < thr) && !sif.blank_mask[m_sel];
        e.sel  = 3'(m_sel);
        e.an   = lit ? ~(8'(1) << m_sel) : 8'hFF;
        e.tick = sif.en && (m_cnt == RD - 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        -> obs_ev;
    endtask

    always @(obs_ev) begin : sb_mon
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got sel=%0d an=%h tick=%b required a queued prediction",
                     sif.seg_sel, sif.an, sif.digit_tick);
        end else begin
            e = sb.pop_front();
            if ({sif.seg_sel, sif.an, sif.digit_tick} !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t got sel=%0d an=%h tick=%b required sel=%0d an=%h tick=%b",
                         $time, sif.seg_sel, sif.an, sif.digit_tick, e.sel, e.an, e.tick);
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ($countones(~sif.an) > 1 ||
                (sif.an !== 8'hFF && sif.an !== ~(8'b1 << sif.seg_sel))) begin
                failures++;
                $display("FAIL anode_onehot t=%0t got an=%h sel=%0d required FF or one low bit at sel",
                         $time, sif.an, sif.seg_sel);
            end
        end
    end

    task automatic align(input int s, input int c);
        for (int i = 0; i < 400 && !(m_sel == s && m_cnt == c); i++) advance();
        checks++;
        if (!(m_sel == s && m_cnt == c)) begin
            failures++;
            $display("FAIL align_timeout got sel=%0d cnt=%0d required sel=%0d cnt=%0d", m_sel, m_cnt, s, c);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        sif.en         = 1'b0;
        sif.brightness = 3'd7;
        sif.blank_mask = 8'h00;
        m_cnt = 0; m_sel = 0; m_bright = 7;
        #12;
        checks++;
        if ({sif.seg_sel, sif.an, sif.digit_tick} !== {3'd0, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL reset_initial got sel=%0d an=%h tick=%b required sel=0 an=ff tick=0",
                     sif.seg_sel, sif.an, sif.digit_tick);
        end
        reset  = 1'b1;
        sif.en = 1'b1;
        align(5, 9);
        checks++;
        if (sif.seg_sel !== 3'd5) begin
            failures++;
            $display("FAIL reset_pre_sel got %0d required 5", sif.seg_sel);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sif.seg_sel, sif.an, sif.digit_tick} !== {3'd0, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL reset_async got sel=%0d an=%h tick=%b required sel=0 an=ff tick=0",
                     sif.seg_sel, sif.an, sif.digit_tick);
        end
        m_cnt = 0; m_sel = 0; m_bright = 7;
        #3 reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            advance();
            checks++;
            if (sif.digit_tick !== (k == 15) || sif.seg_sel !== ((k == 16) ? 3'd1 : 3'd0)) begin
                failures++;
                $display("FAIL reset_restart k=%0d got sel=%0d tick=%b required sel=%0d tick=%b",
                         k, sif.seg_sel, sif.digit_tick, (k == 16) ? 1 : 0, k == 15);
            end
        end
    endtask

    task automatic test_full_scan();
        logic [7:0] ea;
        int ticks = 0;
        sif.brightness = 3'd7;
        sif.blank_mask = 8'h00;
        align(7, 15);
        for (int i = 0; i < 8 * RD; i++) begin
            advance();
            ea = (i % RD == 0) ? 8'hFF : ~(8'b1 << (i / RD));
            if (sif.digit_tick === 1'b1) ticks++;
            checks++;
            if (sif.seg_sel !== 3'(i / RD) || sif.an !== ea || sif.digit_tick !== (i % RD == RD - 1)) begin
                failures++;
                $display("FAIL full_scan i=%0d got sel=%0d an=%h tick=%b required sel=%0d an=%h tick=%b",
                         i, sif.seg_sel, sif.an, sif.digit_tick, i / RD, ea, i % RD == RD - 1);
            end
        end
        checks++;
        if (ticks != 8) begin
            failures++;
            $display("FAIL full_scan_ticks got %0d required 8", ticks);
        end
    endtask

    task automatic test_dimming();
        logic [7:0] ea;
        int sel, c, thr;
        sif.brightness = 3'd1;
        align(7, 15);
        for (int i = 0; i < 5 * RD; i++) begin
            advance();
            sel = i / RD;
            c   = i % RD;
            thr = (sel <= 3) ? 4 : 16;
            ea  = (c >= 1 && c < thr) ? ~(8'b1 << sel) : 8'hFF;
            checks++;
            if (sif.an !== ea || sif.seg_sel !== 3'(sel)) begin
                failures++;
                $display("FAIL dimming i=%0d got sel=%0d an=%h required sel=%0d an=%h",
                         i, sif.seg_sel, sif.an, sel, ea);
            end
            if (sel == 3 && c == 2) sif.brightness = 3'd7;
        end
    endtask

    task automatic test_blanking();
        logic [7:0] ea;
        int sel, c;
        sif.brightness = 3'd7;
        sif.blank_mask = 8'h80;
        align(7, 15);
        for (int i = 0; i < 8 * RD; i++) begin
            advance();
            sel = i / RD;
            c   = i % RD;
            ea  = (c == 0 || sel == 7) ? 8'hFF : ~(8'b1 << sel);
            checks++;
            if (sif.an !== ea || sif.seg_sel !== 3'(sel) || sif.digit_tick !== (c == RD - 1)) begin
                failures++;
                $display("FAIL blanking i=%0d got sel=%0d an=%h tick=%b required sel=%0d an=%h tick=%b",
                         i, sif.seg_sel, sif.an, sif.digit_tick, sel, ea, c == RD - 1);
            end
        end
        sif.blank_mask = 8'h00;
    endtask

    task automatic test_freeze();
        logic [7:0] ea;
        sif.blank_mask = 8'h00;
        sif.brightness = 3'd7;
        align(3, 9);
        sif.en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            advance();
            checks++;
            if ({sif.seg_sel, sif.an, sif.digit_tick} !== {3'd3, 8'hFF, 1'b0}) begin
                failures++;
                $display("FAIL freeze_hold k=%0d got sel=%0d an=%h tick=%b required sel=3 an=ff tick=0",
                         k, sif.seg_sel, sif.an, sif.digit_tick);
            end
        end
        sif.en = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            advance();
            ea = (k == 7) ? 8'hFF : 8'hF7;
            checks++;
            if (sif.digit_tick !== (k == 6) || sif.seg_sel !== ((k == 7) ? 3'd4 : 3'd3) || sif.an !== ea) begin
                failures++;
                $display("FAIL freeze_resume k=%0d got sel=%0d an=%h tick=%b required sel=%0d an=%h tick=%b",
                         k, sif.seg_sel, sif.an, sif.digit_tick, (k == 7) ? 4 : 3, ea, k == 6);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ticks = 0;
        int wraps = 0;
        logic [2:0] prev;
        align(7, 15);
        prev = sif.seg_sel;
        for (int i = 0; i < 3 * 8 * RD; i++) begin
            advance();
            if (sif.digit_tick === 1'b1) ticks++;
            if (prev == 3'd7 && sif.seg_sel == 3'd0) wraps++;
            prev = sif.seg_sel;
        end
        checks++;
        if (ticks != 24 || wraps != 3) begin
            failures++;
            $display("FAIL wrap_frames got ticks=%0d wraps=%0d required ticks=24 wraps=3", ticks, wraps);
        end
        checks++;
        if (sif.seg_sel !== 3'd7) begin
            failures++;
            $display("FAIL wrap_end_sel got %0d required 7", sif.seg_sel);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_scan();
        test_dimming();
        test_blanking();
        test_freeze();
        test_back_to_back();
        #20;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
